ps2_frame_receiver: RTL and testbench

PS/2 device-to-host frame receiver: synchronizes and de-glitches the raw `ps2_clk`/`ps2_data` lines, deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop) and emits each valid byte as a one-cycle strobe. Sits directly upstream of the PS/2 keyboard peripheral, whose prefix/shift decoding, ASCII ROM and receive FIFO consume `data_out`/`data_valid`. Malformed or stalled frames are dropped and reported on `frame_error`.

---
 rtl/ps2_frame_receiver.sv | 190 +++++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// -----------------------------------------------------------------------------
// ps2_frame_receiver
//
// Receives PS/2 device-to-host frames: 1 start bit (0), 8 data bits sent
// LSB first, 1 odd-parity bit and 1 stop bit (1). Both raw lines are
// synchronized into clk. The clock line is also de-glitched. Each good byte
// is presented as a one-cycle strobe. Bad frames are dropped and reported.
//
// Ports:
//   clk          system clock (single domain)
//   rst          synchronous active-high reset
//   ps2_clk      raw PS/2 clock line (asynchronous)
//   ps2_data     raw PS/2 data line (asynchronous)
//   rx_enable    receive enable; low aborts any frame and holds the FSM idle
//   data_out     last correctly received byte, held until the next good frame
//   data_valid   one-cycle strobe; data_out is new in the same cycle
//   frame_error  one-cycle strobe on parity/stop error or inter-bit timeout
// -----------------------------------------------------------------------------
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input path: synchronizers, clock filter, falling-edge detect.
    // This path runs independently of rx_enable.
    // ------------------------------------------------------------------
    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q;
    logic                  fall_q;
    logic                  all_low;
    logic                  all_high;
    logic                  bit_in;

    assign all_low  = (filt_q == '0);
    assign all_high = &filt_q;
    // The data line is sampled in the same cycle that fall is high. The
    // device holds data stable for the whole clock-low phase, so no extra
    // alignment delay is needed.
    assign bit_in   = data_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= '1;
            fclk_q      <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
            // Change level only on a full window of agreeing samples.
            // A mixed window keeps the previous level.
            if (all_low) begin
                fclk_q <= 1'b0;
            end else if (all_high) begin
                fclk_q <= 1'b1;
            end
            // fall is high in the cycle in which fclk is first seen low.
            fall_q <= fclk_q & all_low;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TW-1:0]  to_q, to_d;
    logic [7:0]     data_out_q, data_out_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        to_d       = to_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (!rx_enable) begin
            state_d  = IDLE;
            bitcnt_d = 3'd0;
            to_d     = '0;
        end else if (state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES)) begin
            // The device stalled mid-frame. Drop the partial byte.
            state_d  = IDLE;
            bitcnt_d = 3'd0;
            to_d     = '0;
            err_d    = 1'b1;
        end else begin
            if (state_q == IDLE) begin
                to_d = '0;
            end else begin
                to_d = to_q + TW'(1);
            end

            if (fall_q) begin
                to_d = '0;
                unique case (state_q)
                    IDLE: begin
                        // A high start bit is treated as line noise and is
                        // ignored without reporting an error.
                        if (!bit_in) begin
                            state_d  = DATA;
                            bitcnt_d = 3'd0;
                        end
                    end
                    DATA: begin
                        // Bits arrive LSB first. Shifting right with each new
                        // bit in the MSB leaves the byte in order after 8 bits.
                        shift_d = {bit_in, shift_q[7:1]};
                        if (bitcnt_q == 3'd7) begin
                            state_d = PARITY;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                    PARITY: begin
                        parity_d = bit_in;
                        state_d  = STOP;
                    end
                    STOP: begin
                        state_d = IDLE;
                        if (bit_in && ((^shift_q) ^ parity_q)) begin
                            valid_d    = 1'b1;
                            data_out_d = shift_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            to_q       <= '0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            to_q       <= to_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = valid_q;
    assign frame_error = err_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_frame_receiver
//
// Directed PS/2 frames drive the receiver. Every expected strobe goes into a
// queue when its frame is issued. A negedge monitor pops and compares an
// entry whenever data_valid or frame_error is seen. The PS/2 bit period is
// scaled down (160 clk cycles) so the run stays short. A shorter timeout is
// used for the same reason.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_frame_receiver;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_enable = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;

    ps2_frame_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_enable   (rx_enable),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = good byte, 1 = frame error, 2 = timeout frame error.
    // For error entries, val is the data_out value that must be held.
    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_last_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The device changes data while the clock is high, then drops the clock.
    // When glitch is set, a 5-cycle low pulse is placed in the high phase.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(20);
            ps2_clk = 1'b0;
            wait_cyc(5);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 25);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk    = 1'b0;
        t_last_low = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits bits of a frame. bad_par inverts the odd parity.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(fr[i], i == glitch_bit);
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_error)) begin
            check("strobe_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_strobe: valid=%0b err=%0b data_out=%0h, expected no strobe",
                         data_valid, frame_error, data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("[TB] strobe valid=%0b err=%0b data_out=%02h (expect kind %0d val %02h)",
                         data_valid, frame_error, data_out, e.kind, e.val);
                check("strobe_kind", {31'd0, frame_error}, {31'd0, e.kind != 0});
                check("data_out", {24'd0, data_out}, {24'd0, e.val});
                if (e.kind == 2) begin
                    int d;
                    d = cyc - t_last_low;
                    check("timeout_latency_window",
                          {31'd0, (d >= TO + FL + 3) && (d <= TO + FL + 7)}, 32'd1);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Check the reset state.
        wait_cyc(3);
        check("reset_data_out", {24'd0, data_out}, 32'h00);
        check("reset_data_valid", {31'd0, data_valid}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        wait_cyc(20);

        // Send one good byte.
        push(0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);

        // Send a byte with wrong parity. The held byte must stay 0x1C.
        // Then send a good byte.
        push(1, 8'h1C);
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        push(0, 8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 11, -1);

        // Send two frames back to back.
        push(0, 8'hE0);
        push(0, 8'h75);
        send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
        send_frame(8'h75, 1'b0, 1'b1, 11, -1);

        // Send a frame with a bad stop bit.
        push(1, 8'h75);
        send_frame(8'h12, 1'b0, 1'b0, 11, -1);

        // Abandon a frame after the start bit and 4 data bits, which causes
        // a timeout. Then send a good byte.
        push(2, 8'h75);
        send_frame(8'hA5, 1'b0, 1'b1, 5, -1);
        wait_cyc(TO + 60);
        push(0, 8'h29);
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);

        // Place a glitch while idle and another in the middle of a frame.
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(40);
        push(0, 8'h66);
        send_frame(8'h66, 1'b0, 1'b1, 11, 4);

        // Drop rx_enable after data bit 3 and restore it 10 cycles later.
        // Then send a good byte.
        send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
        rx_enable = 1'b0;
        wait_cyc(10);
        rx_enable = 1'b1;
        wait_cyc(20);
        push(0, 8'h32);
        send_frame(8'h32, 1'b0, 1'b1, 11, -1);

        // Assert reset mid-frame. All outputs must be back at reset values
        // one cycle later.
        send_frame(8'h77, 1'b0, 1'b1, 4, -1);
        rst = 1'b1;
        wait_cyc(1);
        check("midreset_data_out", {24'd0, data_out}, 32'h00);
        check("midreset_data_valid", {31'd0, data_valid}, 32'd0);
        check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        wait_cyc(30);
        push(0, 8'hAA);
        send_frame(8'hAA, 1'b0, 1'b1, 11, -1);

        wait_cyc(50);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
